// File: rtl/out_stream_packer_if.sv
// Stream interface for out_stream_packer: word input side, flush pulse,
// packetised output side with sop/eop, and FIFO occupancy.
interface out_stream_packer_if #(
  parameter int DW    = 32,
  parameter int DEPTH = 8
) ();
  logic                   s_valid;
  logic                   s_ready;
  logic [DW-1:0]          s_data;
  logic                   flush;
  logic                   m_valid;
  logic                   m_ready;
  logic [DW-1:0]          m_data;
  logic                   m_sop;
  logic                   m_eop;
  logic [$clog2(DEPTH):0] level;

  modport slave (
    input  s_valid, s_data, flush, m_ready,
    output s_ready, m_valid, m_data, m_sop, m_eop, level
  );

  modport master (
    output s_valid, s_data, flush, m_ready,
    input  s_ready, m_valid, m_data, m_sop, m_eop, level
  );
endinterface

// File: rtl/out_stream_packer.sv
// Groups an outgoing word stream into PKT_LEN-word packets tagged sop/eop.
// One word is always held back in a staging register so that a partial packet
// can be closed with eop=1 on idle timeout or flush. Tagged words are buffered
// in a show-ahead DEPTH-entry FIFO with valid/ready toward the sink.
module out_stream_packer #(
  parameter int DW      = 32,
  parameter int PKT_LEN = 4,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  out_stream_packer_if.slave io
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(PKT_LEN);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {EMPTY, HOLD} state_t;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
  } entry_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            flush_pend_q, flush_pend_d;
  logic [DW-1:0]   stage_q, stage_d;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     cnt_q, cnt_d;

  logic fifo_full, fifo_empty, pop, accept, push, push_eop, last, timeout_hit;
  entry_t head;

  assign fifo_full   = (cnt_q == (AW+1)'(DEPTH));
  assign fifo_empty  = (cnt_q == '0);
  assign pop         = !fifo_empty && io.m_ready;
  assign io.s_ready  = !rst && ((state_q == EMPTY) || !fifo_full);
  assign accept      = io.s_valid && io.s_ready;
  assign last        = (idx_q == IW'(PKT_LEN - 1));
  // Close fires on the idle cycle that brings the timer up to TIMEOUT.
  assign timeout_hit = (TIMEOUT != 0) && ((32'(timer_q) + 32'd1) >= 32'(TIMEOUT));

  assign head        = mem_q[rd_ptr_q];
  assign io.m_valid  = !fifo_empty;
  assign io.m_data   = fifo_empty ? '0 : head.data;
  assign io.m_sop    = !fifo_empty && head.sop;
  assign io.m_eop    = !fifo_empty && head.eop;
  assign io.level    = cnt_q;

  // Staging FSM: decides when the staged word is pushed and with which eop.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    timer_d      = timer_q;
    flush_pend_d = flush_pend_q;
    stage_d      = stage_q;
    push         = 1'b0;
    push_eop     = 1'b0;
    case (state_q)
      EMPTY: begin
        flush_pend_d = 1'b0;
        timer_d      = '0;
        if (accept) begin
          stage_d = io.s_data;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (accept) begin
          // Accept beats any pending close; the flush is dropped.
          push         = 1'b1;
          push_eop     = last;
          stage_d      = io.s_data;
          timer_d      = '0;
          flush_pend_d = 1'b0;
        end else if (last) begin
          if (!fifo_full) begin
            push     = 1'b1;
            push_eop = 1'b1;
            state_d  = EMPTY;
          end
        end else begin
          if (io.flush) flush_pend_d = 1'b1;
          if (32'(timer_q) < 32'(TIMEOUT)) timer_d = timer_q + TW'(1);
          if ((timeout_hit || io.flush || flush_pend_q) && !fifo_full) begin
            push         = 1'b1;
            push_eop     = 1'b1;
            state_d      = EMPTY;
            timer_d      = '0;
            flush_pend_d = 1'b0;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
    if (push) idx_d = push_eop ? '0 : idx_q + IW'(1);
  end

  // FIFO occupancy next-state.
  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state and FIFO pointers; reset discards staged and buffered words.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      idx_q        <= '0;
      timer_q      <= '0;
      flush_pend_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      timer_q      <= timer_d;
      flush_pend_q <= flush_pend_d;
      cnt_q        <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // Datapath storage needs no reset; outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    stage_q <= stage_d;
    if (push) mem_q[wr_ptr_q] <= '{sop: (idx_q == '0), eop: push_eop, data: stage_q};
  end
endmodule
